// File: rtl/ramp_table_player_if.sv
// ramp_table_player_if: table write bus (AXI reg side) and DAC setpoint output of the ramp player
// master: drives ram_we/ram_waddr/ram_wdata, observes dac_setpt/dac_valid
// slave : the player; accepts table writes, drives dac_setpt/dac_valid
interface ramp_table_player_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 20
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] dac_setpt;
  logic              dac_valid;
  modport master (output ram_we, ram_waddr, ram_wdata, input dac_setpt, dac_valid);
  modport slave (input ram_we, ram_waddr, ram_wdata, output dac_setpt, dac_valid);
endinterface

// File: rtl/ramp_table_player.sv
// ramp_table_player: plays back the PSC ramp table, one DAC setpoint per timing tick
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   bus (slave)      table write port (ram_we/ram_waddr/ram_wdata), DAC out (dac_setpt/dac_valid)
//   ramplen_i        last index to play, latched on the run rising edge
//   run_i            start on rising edge (ignored unless idle)
//   abort_i          level stop, wins over run/tick
//   tick_i           1-clk advance strobe
//   active_o         playback in progress
//   done_o           1-clk strobe together with the last sample
//   overrun_o        sticky: tick arrived while a read was in flight
//   cur_addr_o       next index to play
// Option: define RAMP_LOOP_EN to wrap to index 0 after the last entry instead of finishing.
module ramp_table_player #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ramp_table_player_if.slave    bus,
  input  logic [ADDR_W-1:0]     ramplen_i,
  input  logic                  run_i,
  input  logic                  abort_i,
  input  logic                  tick_i,
  output logic                  active_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic [ADDR_W-1:0]     cur_addr_o
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, LOAD} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] setpt_q, setpt_d;
  logic [ADDR_W-1:0] cur_q, cur_d, len_q, len_d;
  logic              valid_q, valid_d, done_q, done_d, active_q, active_d, ovr_q, ovr_d, run_q;
  // cur_q is stable from the tick through LOAD, so reading it every cycle yields the
  // entry in READ and presents it in LOAD; nonblocking write gives read-first on collision
  always_ff @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    ram_q <= mem[cur_q];
  end
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    len_d    = len_q;
    setpt_d  = setpt_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    active_d = active_q;
    ovr_d    = ovr_q;
    if (abort_i) begin
      state_d  = IDLE;
      active_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (run_i && !run_q) begin
          cur_d    = '0;
          len_d    = ramplen_i;
          ovr_d    = 1'b0;
          active_d = 1'b1;
          state_d  = WAIT;
        end
        WAIT: state_d = tick_i ? READ : WAIT;
        READ: begin
          ovr_d   = ovr_q | tick_i;
          state_d = LOAD;
        end
        default: begin
          ovr_d   = ovr_q | tick_i;
          setpt_d = ram_q;
          valid_d = 1'b1;
          state_d = WAIT;
          if (cur_q == len_q) begin
`ifdef RAMP_LOOP_EN
            cur_d = '0;
`else
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = IDLE;
`endif
          end else begin
            cur_d = cur_q + 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      len_q    <= '0;
      setpt_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      ovr_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      len_q    <= len_d;
      setpt_q  <= setpt_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      active_q <= active_d;
      ovr_q    <= ovr_d;
      run_q    <= run_i;
    end
  end
  assign bus.dac_setpt = setpt_q;
  assign bus.dac_valid = valid_q;
  assign active_o      = active_q;
  assign done_o        = done_q;
  assign overrun_o     = ovr_q;
  assign cur_addr_o    = cur_q;
endmodule

// File: tb/tb_ramp_table_player.sv
// tb_ramp_table_player: randomized self-checking bench for ramp_table_player against a table/index model
module tb_ramp_table_player;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] ramplen = '0;
  logic        run = 1'b0, abort = 1'b0, tick = 1'b0;
  logic        active, done, overrun;
  logic [12:0] cur_addr;
  logic [19:0] mdl [0:8191];
  logic [19:0] lastv;
  int          idx, lenm, errs, checks;
  ramp_table_player_if #(.ADDR_W(13), .DATA_W(20)) bus ();
  ramp_table_player #(.ADDR_W(13), .DATA_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .ramplen_i(ramplen), .run_i(run),
    .abort_i(abort), .tick_i(tick), .active_o(active), .done_o(done),
    .overrun_o(overrun), .cur_addr_o(cur_addr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic [19:0] d);
    bus.ram_we = 1'b1;
    bus.ram_waddr = 13'(a);
    bus.ram_wdata = d;
    step();
    bus.ram_we = 1'b0;
    mdl[a] = d;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_cur"}, cur_addr, 0);
    chk({tag, "_valid"}, bus.dac_valid, 0);
    chk({tag, "_setpt"}, bus.dac_setpt, 0);
  endtask
  task automatic start(input int l);
    ramplen = 13'(l);
    run = 1'b1;
    step();
    run = 1'b0;
    ramplen = 13'($urandom);
    idx = 0;
    lenm = l;
    chk("start_active", active, 1);
    chk("start_overrun", overrun, 0);
    chk("start_cur", cur_addr, 0);
  endtask
  task automatic stop();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_active", active, 0);
    chk("abort_valid", bus.dac_valid, 0);
    chk("abort_done", done, 0);
  endtask
  // one accepted tick: sample must appear exactly 3 clocks after the tick
  task automatic do_tick();
    logic last;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    chk("early_valid", bus.dac_valid, 0);
    chk("early_done", done, 0);
    step();
    last = (idx == lenm);
    chk("valid", bus.dac_valid, 1);
    chk("setpt", bus.dac_setpt, mdl[idx]);
    lastv = mdl[idx];
`ifdef RAMP_LOOP_EN
    chk("done", done, 0);
    chk("active", active, 1);
    idx = last ? 0 : idx + 1;
`else
    chk("done", done, 32'(last));
    chk("active", active, 32'(!last));
    if (!last) idx++;
`endif
    chk("cur_addr", cur_addr, idx);
    step();
    chk("strobe_end", bus.dac_valid, 0);
    chk("done_end", done, 0);
    repeat ($urandom_range(0, 6)) step();
  endtask
  task automatic end_ramp();
`ifdef RAMP_LOOP_EN
    repeat (lenm + 2) do_tick();
    stop();
`else
    chk("end_active", active, 0);
`endif
  endtask
  task automatic fill_rand(input int n);
    for (int i = 0; i <= n; i++) wr(i, 20'($urandom));
  endtask
  initial begin
    bus.ram_we = 1'b0;
    bus.ram_waddr = '0;
    bus.ram_wdata = '0;
    errs = 0;
    checks = 0;
    step();
    step();
    chk_zero("reset");
    reset_n = 1'b1;
    step();
    // full ramp of ram[i]=i
    for (int i = 0; i <= 100; i++) wr(i, 20'(i));
    start(100);
    repeat (101) do_tick();
    end_ramp();
    // single-sample ramp
    wr(0, 20'hABCDE);
    start(0);
    do_tick();
    end_ramp();
    // ticks while idle are ignored without overrun
    repeat (3) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (3) begin
        step();
        chk("idle_valid", bus.dac_valid, 0);
        chk("idle_overrun", overrun, 0);
      end
    end
    // random ramp with live writes, ignored re-run, then abort
    begin
      int l, k;
      l = $urandom_range(20, 60);
      k = $urandom_range(5, l - 5);
      fill_rand(l);
      start(l);
      repeat (k) begin
        if (idx + 2 <= lenm) wr(idx + 2, 20'($urandom));
        do_tick();
      end
      run = 1'b1;
      ramplen = 13'd3;
      step();
      run = 1'b0;
      step();
      chk("rerun_cur", cur_addr, idx);
      chk("rerun_active", active, 1);
      do_tick();
      do_tick();
      stop();
      chk("abort_hold", bus.dac_setpt, lastv);
      repeat (3) begin
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (3) begin
          step();
          chk("post_abort_valid", bus.dac_valid, 0);
          chk("post_abort_setpt", bus.dac_setpt, lastv);
        end
      end
    end
    // back-to-back ticks: one sample, sticky overrun
    fill_rand(10);
    start(10);
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    step();
    chk("ovr_valid", bus.dac_valid, 1);
    chk("ovr_setpt", bus.dac_setpt, mdl[0]);
    chk("ovr_flag", overrun, 1);
    idx = 1;
    step();
    do_tick();
    chk("ovr_sticky", overrun, 1);
    stop();
    chk("ovr_after_abort", overrun, 1);
    // tick on the run edge is ignored; run edge also clears overrun
    run = 1'b1;
    tick = 1'b1;
    ramplen = 13'd10;
    step();
    run = 1'b0;
    tick = 1'b0;
    idx = 0;
    lenm = 10;
    chk("runtick_overrun", overrun, 0);
    repeat (3) begin
      step();
      chk("runtick_valid", bus.dac_valid, 0);
    end
    do_tick();
    stop();
    // reset mid-ramp keeps RAM contents
    fill_rand(40);
    start(40);
    repeat (31) do_tick();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_zero("midreset");
    step();
    start(40);
    repeat (5) do_tick();
    stop();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
